// File: rtl/mem_responder.sv
// Synthesizable word-addressed memory responder: fixed-latency in-order reads,
// single-cycle writes, response FIFO with backpressure and sticky error flags.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif

module mem_responder #(
  parameter int ADDR_W          = `MEM_ADDR_SIZE,
  parameter int DATA_W          = `MEM_BANDWIDTH * 8,
  parameter int DEPTH           = 1024,
  parameter int READ_LATENCY    = 4,
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_req,
  input  logic              mem_write_valid,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              resp_stall,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_valid,
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_collision,
  output logic              err_overflow,
  output logic              err_addr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int NS = READ_LATENCY - 1;

  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic [DATA_W-1:0] fifo_q [MAX_OUTSTANDING];

  logic              addr_oob;
  logic [AW-1:0]     idx;
  logic              wr_en, rd_try, accept, pop;
  logic [DATA_W-1:0] rd_data;
  logic              push_vld;
  logic [DATA_W-1:0] push_dat;

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_after_pop;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              err_coll_q, err_coll_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_addr_q, err_addr_d;

  // DEPTH is a power of two, so any set bit above the index field is out of range
  generate
    if (ADDR_W > AW) begin : g_wide_addr
      assign addr_oob = |mem_addr[ADDR_W-1:AW];
      assign idx      = mem_addr[AW-1:0];
    end else begin : g_narrow_addr
      assign addr_oob = 1'b0;
      assign idx      = AW'(mem_addr);
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_en         = mem_write_valid && !clear && !addr_oob;
    rd_try        = mem_rd_req && !mem_write_valid && !clear;
    pop           = (fcnt_q != '0) && !resp_stall;
    cnt_after_pop = cnt_q - CNT_W'(pop);
    accept        = rd_try && (cnt_after_pop < CNT_W'(MAX_OUTSTANDING));
    rd_data       = addr_oob ? '0 : mem_q[idx];
  end

  // Read pipeline: READ_LATENCY-1 stages between acceptance and FIFO push
  generate
    if (NS == 0) begin : g_nopipe
      assign push_vld = accept;
      assign push_dat = rd_data;
    end else begin : g_pipe
      logic [NS-1:0]     vld_q, vld_d;
      logic [DATA_W-1:0] dat_q [NS];
      logic [DATA_W-1:0] dat_d [NS];

      always_comb begin
        vld_d    = '0;
        vld_d[0] = accept;
        dat_d[0] = rd_data;
        for (int unsigned i = 1; i < NS; i++) begin
          vld_d[i] = vld_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
        if (clear) vld_d = '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
      end

      always_ff @(posedge clk) begin
        dat_q <= dat_d;
      end

      assign push_vld = vld_q[NS-1];
      assign push_dat = dat_q[NS-1];
    end
  endgenerate

  always_comb begin
    cnt_d      = cnt_q + CNT_W'(accept) - CNT_W'(pop);
    wr_ptr_d   = push_vld ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fcnt_d     = fcnt_q + CNT_W'(push_vld) - CNT_W'(pop);
    err_coll_d = err_coll_q | (mem_rd_req && mem_write_valid);
    err_ovf_d  = err_ovf_q | (rd_try && !accept);
    err_addr_d = err_addr_q | ((mem_rd_req || mem_write_valid) && addr_oob);
    if (clear) begin
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fcnt_d     = '0;
      err_coll_d = 1'b0;
      err_ovf_d  = 1'b0;
      err_addr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      err_coll_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      err_coll_q <= err_coll_d;
      err_ovf_q  <= err_ovf_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= mem_write_data;
    if (push_vld && !clear) fifo_q[wr_ptr_q] <= push_dat;
  end

  always_comb begin
    mem_valid     = pop;
    mem_data      = pop ? fifo_q[rd_ptr_q] : '0;
    outstanding   = cnt_q;
    err_collision = err_coll_q;
    err_overflow  = err_ovf_q;
    err_addr      = err_addr_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with READ_LATENCY=4, MAX_OUTSTANDING=16.
module tb_mem_responder;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 4;
  localparam int MAXO   = 16;
  localparam int CW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              rd = 1'b0;
  logic              wv = 1'b0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic [CW-1:0]     outstanding;
  logic              ec, eo, ea;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .READ_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .mem_addr(addr), .mem_rd_req(rd), .mem_write_valid(wv), .mem_write_data(wdata),
    .resp_stall(stall), .mem_data(mem_data), .mem_valid(mem_valid),
    .outstanding(outstanding), .err_collision(ec), .err_overflow(eo), .err_addr(ea)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input int a, input logic [DATA_W-1:0] d);
    rd = r; wv = w; addr = ADDR_W'(a); wdata = d;
  endtask

  task automatic do_clear();
    cyc(); drive(0, 0, 0, 0); clear = 1'b1;
    cyc(); clear = 1'b0;
  endtask

  // Issues one read and reports the cycle offset and data of the first response seen.
  task automatic do_read_wait(input int a, output logic [DATA_W-1:0] data, output int lat);
    cyc(); drive(1, 0, a, 0);
    lat = -1; data = '0;
    for (int i = 1; i <= 12; i++) begin
      cyc(); drive(0, 0, 0, 0); #1;
      if (mem_valid && lat < 0) begin lat = i; data = mem_data; end
    end
  endtask

  task automatic test_reset();
    cyc(); #1;
    vecs++; if ({mem_valid, mem_data, outstanding, ec, eo, ea} !== '0) begin errs++;
      $display("FAIL reset_hold: got valid=%b data=%0h out=%0d flags=%b%b%b expected all 0",
               mem_valid, mem_data, outstanding, ec, eo, ea); end
    rst_n = 1'b1;
    cyc(); #1;
    vecs++; if ({mem_valid, mem_data, outstanding, ec, eo, ea} !== '0) begin errs++;
      $display("FAIL reset_release: got valid=%b data=%0h out=%0d expected all 0",
               mem_valid, mem_data, outstanding); end
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0)      drive(0, 1, 5, 32'hA5A5);
      else if (k == 1) drive(1, 0, 5, 0);
      else             drive(0, 0, 0, 0);
      #1;
      vecs++; if (mem_valid !== (k == 5)) begin errs++;
        $display("FAIL wr_rd_valid c%0d: got %b expected %b", k, mem_valid, (k == 5)); end
      vecs++; if (outstanding !== ((k >= 2 && k <= 5) ? 5'd1 : 5'd0)) begin errs++;
        $display("FAIL wr_rd_outstanding c%0d: got %0d expected %0d", k, outstanding,
                 (k >= 2 && k <= 5) ? 1 : 0); end
      vecs++; if (mem_data !== ((k == 5) ? 32'hA5A5 : 32'h0)) begin errs++;
        $display("FAIL wr_rd_data c%0d: got %0h expected %0h", k, mem_data,
                 (k == 5) ? 32'hA5A5 : 32'h0); end
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 16; i++) begin cyc(); drive(0, 1, i, 32'(100 + i)); end
    for (int k = 0; k < 24; k++) begin
      cyc(); drive(k < 16, 0, k, 0); #1;
      vecs++; if (mem_valid !== (k >= 4 && k < 20)) begin errs++;
        $display("FAIL burst_valid c%0d: got %b expected %b", k, mem_valid, (k >= 4 && k < 20)); end
      if (k >= 4 && k < 20) begin
        vecs++; if (mem_data !== 32'(100 + k - 4)) begin errs++;
          $display("FAIL burst_data c%0d: got %0d expected %0d", k, mem_data, 100 + k - 4); end
      end
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int k = 0; k < 22; k++) begin
      cyc(); stall = 1'b1;
      if (k < 17) drive(1, 0, k % 16, 0); else drive(0, 0, 0, 0);
      #1;
      vecs++; if (mem_valid !== 1'b0) begin errs++;
        $display("FAIL ovf_stalled_valid c%0d: got %b expected 0", k, mem_valid); end
      if (k == 16) begin
        vecs++; if (outstanding !== 5'd16) begin errs++;
          $display("FAIL ovf_full_count: got %0d expected 16", outstanding); end
        vecs++; if (eo !== 1'b0) begin errs++;
          $display("FAIL ovf_flag_early: got %b expected 0", eo); end
      end
      if (k == 17) begin
        vecs++; if (eo !== 1'b1) begin errs++;
          $display("FAIL ovf_flag: got %b expected 1", eo); end
        vecs++; if (outstanding !== 5'd16) begin errs++;
          $display("FAIL ovf_count_held: got %0d expected 16", outstanding); end
      end
    end
    for (int k = 0; k < 22; k++) begin
      cyc(); stall = 1'b0; drive(0, 0, 0, 0); #1;
      vecs++; if (mem_valid !== (k < 16)) begin errs++;
        $display("FAIL ovf_drain_valid c%0d: got %b expected %b", k, mem_valid, (k < 16)); end
      if (k < 16) begin
        vecs++; if (mem_data !== 32'(100 + k)) begin errs++;
          $display("FAIL ovf_drain_data c%0d: got %0d expected %0d", k, mem_data, 100 + k); end
      end
    end
    vecs++; if (outstanding !== 5'd0) begin errs++;
      $display("FAIL ovf_drained_count: got %0d expected 0", outstanding); end
    do_clear(); #1;
    vecs++; if (eo !== 1'b0) begin errs++;
      $display("FAIL ovf_flag_cleared: got %b expected 0", eo); end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] d;
    int lat;
    cyc(); drive(1, 1, 3, 32'h77); #1;
    vecs++; if (ec !== 1'b0) begin errs++;
      $display("FAIL coll_flag_early: got %b expected 0", ec); end
    for (int k = 1; k < 8; k++) begin
      cyc(); drive(0, 0, 0, 0); #1;
      vecs++; if (mem_valid !== 1'b0 || ec !== 1'b1 || outstanding !== 5'd0) begin errs++;
        $display("FAIL coll_no_resp c%0d: got valid=%b flag=%b out=%0d expected 0/1/0",
                 k, mem_valid, ec, outstanding); end
    end
    do_read_wait(3, d, lat);
    vecs++; if (lat !== LAT || d !== 32'h77) begin errs++;
      $display("FAIL coll_readback: got lat=%0d data=%0h expected lat=%0d data=77", lat, d, LAT); end
  endtask

  task automatic test_addr();
    logic [DATA_W-1:0] d;
    int lat;
    do_clear(); #1;
    vecs++; if (ea !== 1'b0) begin errs++;
      $display("FAIL addr_flag_pre: got %b expected 0", ea); end
    do_read_wait(DEPTH + 2, d, lat);
    vecs++; if (lat !== LAT || d !== 32'h0) begin errs++;
      $display("FAIL addr_oob_read: got lat=%0d data=%0h expected lat=%0d data=0", lat, d, LAT); end
    vecs++; if (ea !== 1'b1) begin errs++;
      $display("FAIL addr_flag_read: got %b expected 1", ea); end
    do_clear();
    cyc(); drive(0, 1, DEPTH, 32'hDEAD);
    cyc(); drive(0, 0, 0, 0); #1;
    vecs++; if (ea !== 1'b1) begin errs++;
      $display("FAIL addr_flag_write: got %b expected 1", ea); end
    do_read_wait(0, d, lat);
    vecs++; if (lat !== LAT || d !== 32'd100) begin errs++;
      $display("FAIL addr_oob_write_ignored: got lat=%0d data=%0h expected lat=%0d data=64", lat, d, LAT); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      cyc(); stall = (k == 7);
      case (k)
        0: drive(0, 1, 20, 32'hBEEF);
        1: drive(1, 0, 20, 0);
        2: drive(0, 1, 21, 32'hCAFE);
        3: drive(1, 0, 21, 0);
        4: drive(1, 0, 20, 0);
        default: drive(0, 0, 0, 0);
      endcase
      #1;
      vecs++; if (mem_valid !== (k == 5 || k == 8 || k == 9)) begin errs++;
        $display("FAIL b2b_valid c%0d: got %b expected %b", k, mem_valid, (k == 5 || k == 8 || k == 9)); end
      vecs++; if (mem_data !== ((k == 5 || k == 9) ? 32'hBEEF : (k == 8) ? 32'hCAFE : 32'h0)) begin
        errs++;
        $display("FAIL b2b_data c%0d: got %0h expected %0h", k, mem_data,
                 (k == 5 || k == 9) ? 32'hBEEF : (k == 8) ? 32'hCAFE : 32'h0); end
    end
    stall = 1'b0;
  endtask

  task automatic test_clear();
    logic [DATA_W-1:0] d;
    int lat;
    cyc(); drive(0, 1, 7, 32'h1234);
    cyc(); drive(1, 1, 8, 32'h55);
    cyc(); drive(1, 0, 7, 0);
    cyc(); drive(1, 0, 7, 0);
    cyc(); drive(1, 0, 7, 0); clear = 1'b1; #1;
    vecs++; if (ec !== 1'b1 || outstanding !== 5'd2) begin errs++;
      $display("FAIL clr_pre: got flag=%b out=%0d expected 1/2", ec, outstanding); end
    for (int k = 0; k < 8; k++) begin
      cyc(); clear = 1'b0; drive(0, 0, 0, 0); #1;
      vecs++; if (mem_valid !== 1'b0 || outstanding !== 5'd0 || {ec, eo, ea} !== 3'b000) begin
        errs++;
        $display("FAIL clr_flush c%0d: got valid=%b out=%0d flags=%b%b%b expected 0/0/000",
                 k, mem_valid, outstanding, ec, eo, ea); end
    end
    do_read_wait(7, d, lat);
    vecs++; if (lat !== LAT || d !== 32'h1234) begin errs++;
      $display("FAIL clr_array_kept: got lat=%0d data=%0h expected lat=%0d data=1234", lat, d, LAT); end
    do_read_wait(8, d, lat);
    vecs++; if (lat !== LAT || d !== 32'h55) begin errs++;
      $display("FAIL clr_coll_write: got lat=%0d data=%0h expected lat=%0d data=55", lat, d, LAT); end
  endtask

  task automatic test_reset_mid();
    cyc(); drive(0, 1, 9, 32'h99);
    cyc(); drive(1, 0, 9, 0);
    cyc(); drive(1, 0, 9, 0);
    cyc(); drive(1, 1, 9, 32'h99);
    cyc(); drive(0, 0, 0, 0); #1;
    vecs++; if (ec !== 1'b1 || outstanding !== 5'd2) begin errs++;
      $display("FAIL rst_mid_pre: got flag=%b out=%0d expected 1/2", ec, outstanding); end
    rst_n = 1'b0; #1;
    vecs++; if ({mem_valid, mem_data, outstanding, ec, eo, ea} !== '0) begin errs++;
      $display("FAIL rst_mid_async: got valid=%b out=%0d flag=%b expected all 0",
               mem_valid, outstanding, ec); end
    cyc(); cyc(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      vecs++; if (mem_valid !== 1'b0 || outstanding !== 5'd0) begin errs++;
        $display("FAIL rst_mid_discard c%0d: got valid=%b out=%0d expected 0/0", k, mem_valid, outstanding); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_overflow();
    test_collision();
    test_addr();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
